// File: rtl/nes_pkg.sv
// nes_pkg: NES bus constants and the OAM DMA state encoding.
// Shared by every block that needs the $4014/$2004 addresses.
package nes_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// oam_dma: copies one 256-byte CPU page into OAM through OAM_DATA_ADDR, stalling the CPU.
// The bus mux is combinational from registered state; all state lives in one always_ff.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_we,
    input  logic [7:0]  mem_d_in,
    output logic        dma_busy
);

    dma_state_e  state_q;
    logic        parity_q;
    logic [7:0]  idx_q;
    logic [7:0]  page_q;
    logic [7:0]  buf_q;
    logic        trigger;
    logic        last;

    assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign last    = (idx_q == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
            buf_q    <= 8'h00;
        end else begin
            parity_q <= ~parity_q;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        page_q  <= cpu_d_out;
                        idx_q   <= 8'h00;
                        state_q <= HALT;
                    end
                end
                // An odd HALT needs one extra cycle so every READ lands on parity 1
                HALT:  state_q <= parity_q ? ALIGN : READ;
                ALIGN: state_q <= READ;
                READ: begin
                    buf_q   <= mem_d_in;
                    state_q <= WRITE;
                end
                WRITE: begin
                    state_q <= last ? IDLE : READ;
                    if (!last) idx_q <= idx_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_rdy   = (state_q == IDLE);
        dma_busy  = (state_q != IDLE);
        mem_addr  = (state_q == READ)  ? {page_q, idx_q} :
                    (state_q == WRITE) ? OAM_DATA_ADDR   : cpu_addr;
        mem_d_out = (state_q == WRITE) ? buf_q : cpu_d_out;
        mem_we    = (state_q == IDLE)  ? cpu_we : (state_q == WRITE);
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed scenarios for oam_dma against a byte=addr[7:0] memory.
// A small parity model picks the trigger cycle for aligned/unaligned transfers.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_d_out = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_we;
    logic [7:0]  mem_d_in;
    logic        dma_busy;
    logic        par_m = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    oam_dma dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
        .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .mem_addr(mem_addr),
        .mem_d_out(mem_d_out), .mem_we(mem_we), .mem_d_in(mem_d_in),
        .dma_busy(dma_busy)
    );

    always #5 clk = ~clk;
    assign mem_d_in = mem_addr[7:0];
    always @(posedge clk) par_m <= rst ? ~par_m : 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_addr = 16'h1234; cpu_d_out = 8'hA5; cpu_we = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        n_chk++;
        if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || mem_addr !== 16'h1234 || mem_we !== 1'b0 || mem_d_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b busy=%b addr=%h we=%b d=%h, want rdy=1 busy=0 addr=1234 we=0 d=a5",
                     cpu_rdy, dma_busy, mem_addr, mem_we, mem_d_out);
        end
    endtask

    task automatic test_passthrough();
        step();
        cpu_addr = 16'h0300; cpu_d_out = 8'h5A; cpu_we = 1'b1;
        #1;
        n_chk++;
        if (mem_addr !== 16'h0300 || mem_d_out !== 8'h5A || mem_we !== 1'b1 || cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL passthrough: addr=%h d=%h we=%b rdy=%b busy=%b, want 0300 5a 1 1 0",
                     mem_addr, mem_d_out, mem_we, cpu_rdy, dma_busy);
        end
        step();
        cpu_we = 1'b0;
        #1;
        n_chk++;
        if (dma_busy !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL passthrough_after: busy=%b we=%b, want 0 0", dma_busy, mem_we);
        end
    endtask

    // Trigger so that HALT has parity want_align; trigger cycle has the opposite parity
    task automatic trigger(input logic [7:0] pg, input logic want_align, input string nm);
        cpu_we = 1'b0;
        for (int k = 0; k < 4 && par_m !== !want_align; k++) step();
        cpu_addr = 16'h4014; cpu_d_out = pg; cpu_we = 1'b1;
        #1;
        n_chk++;
        if (mem_addr !== 16'h4014 || mem_d_out !== pg || mem_we !== 1'b1 || cpu_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_trigger_on_bus: addr=%h d=%h we=%b rdy=%b, want 4014 %h 1 1",
                     nm, mem_addr, mem_d_out, mem_we, cpu_rdy, pg);
        end
    endtask

    task automatic run_dma(input logic [7:0] pg, input logic want_align, input string nm);
        int lows = 0;
        int writes = 0;
        int bad = 0;
        int cyc = 0;
        logic done = 1'b0;
        logic [15:0] prev_addr = 16'h0000;
        logic [15:0] last_read = 16'h0000;
        int want_lows;
        want_lows = want_align ? 514 : 513;
        trigger(pg, want_align, nm);
        while (!done && cyc < 700) begin
            step();
            // Keep hammering $4014 early on: those writes must be ignored mid-transfer
            if (cyc < 10) begin
                cpu_addr = 16'h4014; cpu_d_out = 8'h77; cpu_we = 1'b1;
            end else begin
                cpu_addr = 16'h0555; cpu_d_out = 8'h33; cpu_we = 1'b0;
            end
            #1;
            cyc++;
            if (cpu_rdy) done = 1'b1;
            else lows++;
            if (dma_busy !== !cpu_rdy) bad++;
            if (!cpu_rdy && mem_we) begin
                if (mem_addr !== 16'h2004 || mem_d_out !== writes[7:0] || prev_addr !== {pg, writes[7:0]}) bad++;
                last_read = prev_addr;
                writes++;
            end
            prev_addr = mem_addr;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: transfer did not finish in 700 cycles", nm);
        end
        n_chk++;
        if (lows !== want_lows) begin
            n_fail++;
            $display("FAIL %s_stall_cycles: got %0d, want %0d", nm, lows, want_lows);
        end
        n_chk++;
        if (writes !== 256) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d, want 256", nm, writes);
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s_bus_sequence: %0d bad cycles, want 0", nm, bad);
        end
        n_chk++;
        if (last_read !== {pg, 8'hFF}) begin
            n_fail++;
            $display("FAIL %s_last_read: got %h, want %h", nm, last_read, {pg, 8'hFF});
        end
        n_chk++;
        if (mem_addr !== 16'h0555 || dma_busy !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_back_to_idle: addr=%h busy=%b we=%b, want 0555 0 0", nm, mem_addr, dma_busy, mem_we);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int stray = 0;
        logic hit = 1'b0;
        trigger(8'h12, 1'b0, "rstmid");
        while (!hit && cyc < 300) begin
            step();
            cpu_addr = 16'h0777; cpu_d_out = 8'h00; cpu_we = 1'b0;
            #1;
            cyc++;
            if (!cpu_rdy && !mem_we && mem_addr === 16'h1240) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rstmid_reach_idx40: read of 1240 not seen in 300 cycles");
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_chk++;
        if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || mem_addr !== 16'h0777) begin
            n_fail++;
            $display("FAIL rstmid_abort: rdy=%b busy=%b addr=%h, want 1 0 0777", cpu_rdy, dma_busy, mem_addr);
        end
        for (int k = 0; k < 600; k++) begin
            step();
            if (mem_we || !cpu_rdy || mem_addr === 16'h2004) stray++;
        end
        n_chk++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL rstmid_no_resume: %0d DMA cycles after reset, want 0", stray);
        end
    endtask

    task automatic test_non_trigger();
        int bad = 0;
        step();
        cpu_addr = 16'h4015; cpu_d_out = 8'h03; cpu_we = 1'b1;
        #1;
        n_chk++;
        if (mem_addr !== 16'h4015 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL nontrig_pass: addr=%h we=%b, want 4015 1", mem_addr, mem_we);
        end
        step();
        cpu_addr = 16'h4014; cpu_d_out = 8'h03; cpu_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            cpu_addr = 16'h0000;
            if (dma_busy !== 1'b0 || cpu_rdy !== 1'b1) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL nontrig_no_dma: %0d busy cycles, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        run_dma(8'h02, 1'b0, "even");
        run_dma(8'h02, 1'b1, "odd");
        run_dma(8'hFF, 1'b0, "wrap");
        test_reset_mid();
        test_non_trigger();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The module SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU write address that triggers DMA.
REQ-002 The module SHALL have parameter OAM_DATA_ADDR, default 16'h2004, the destination address for every DMA write.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port cpu_addr, input, 16 bits: CPU address.
REQ-006 The module SHALL have port cpu_d_out, input, 8 bits: CPU write data.
REQ-007 The module SHALL have port cpu_we, input, 1 bit: CPU write strobe.
REQ-008 The module SHALL have port cpu_rdy, output, 1 bit: 1 means the CPU may advance, 0 means the CPU is stalled.
REQ-009 The module SHALL have port mem_addr, output, 16 bits: shared memory bus address.
REQ-010 The module SHALL have port mem_d_out, output, 8 bits: shared memory bus write data.
REQ-011 The module SHALL have port mem_we, output, 1 bit: shared memory bus write strobe.
REQ-012 The module SHALL have port mem_d_in, input, 8 bits: read data, valid in the same cycle the address is presented.
REQ-013 The module SHALL have port dma_busy, output, 1 bit: 1 whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 A 1-bit parity register SHALL toggle every clock; it SHALL be 0 in the first cycle after reset.
REQ-016 In IDLE: mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_we=cpu_we, cpu_rdy=1.
REQ-017 In IDLE, cpu_we=1 with cpu_addr==DMA_REG_ADDR SHALL, at that edge:
  - latch page <= cpu_d_out;
  - clear the 8-bit index idx to 0;
  - enter HALT.
  The triggering write itself SHALL appear on the mem bus.
REQ-018 In HALT and ALIGN: cpu_rdy=0, mem_addr=cpu_addr, mem_we=0.
REQ-019 HALT SHALL last exactly one cycle; next state is ALIGN if parity==1 during HALT, else READ.
REQ-020 ALIGN SHALL last exactly one cycle, then READ; as a result every READ cycle falls on parity 1.
REQ-021 In READ: mem_addr={page,idx}, mem_we=0, cpu_rdy=0; mem_d_in is latched into an 8-bit buffer; next state is WRITE.
REQ-022 In WRITE: mem_addr=OAM_DATA_ADDR, mem_d_out=buffer, mem_we=1, cpu_rdy=0.
  - If idx==8'hFF, next state is IDLE.
  - Otherwise idx <= idx+1 and next state is READ.
REQ-023 idx SHALL NOT carry into page; with page 8'hFF the last read address SHALL be 16'hFFFF.
REQ-024 A transfer SHALL be exactly 256 read/write pairs; total cpu_rdy-low cycles SHALL be 513 (no ALIGN) or 514 (with ALIGN).
REQ-025 CPU accesses to DMA_REG_ADDR while not IDLE SHALL be ignored, and no CPU write SHALL reach the mem bus while not IDLE.
REQ-026 A write to any other address, or a read of DMA_REG_ADDR, SHALL NOT start DMA.

Reset
REQ-027 While rst==0 at a clock edge, the next state SHALL be: state=IDLE, parity=0, idx=0, page=0, buffer=0.
REQ-028 After reset: cpu_rdy=1, dma_busy=0, and mem outputs follow the IDLE pass-through.
REQ-029 Reset asserted mid-transfer SHALL abort immediately: no further DMA bus cycles, and the transfer SHALL NOT resume.

Structure
REQ-030 The state enum and the 16'h4014 / 16'h2004 address constants SHALL live in shared package nes_pkg.
REQ-031 The block SHALL be a single module with no sub-module; the bus mux SHALL be combinational from registered state.

Verification
REQ-032 Scenario, idle pass-through: cpu_addr=16'h0300, cpu_d_out=8'h5A, cpu_we=1 -> same cycle mem_addr=16'h0300, mem_d_out=8'h5A, mem_we=1, cpu_rdy=1, dma_busy=0.
REQ-033 Scenario, even-aligned DMA: write 8'h02 to 16'h4014 so that HALT has parity 0, memory holding byte=addr[7:0] -> cpu_rdy low 513 cycles, reads 16'h0200..16'h02FF, writes 8'h00..8'hFF to 16'h2004, then IDLE.
REQ-034 Scenario, odd-aligned DMA: same trigger with HALT on parity 1 -> one ALIGN cycle, cpu_rdy low 514 cycles, same data sequence.
REQ-035 Scenario, page wrap: page 8'hFF -> last READ address 16'hFFFF, followed by exactly one WRITE, then IDLE with no read of 16'hFF00.
REQ-036 Scenario, reset mid-transfer: rst=0 for one edge when idx==8'h40 -> next cycle cpu_rdy=1, dma_busy=0, mem_addr=cpu_addr, and no further writes to 16'h2004.
REQ-037 Scenario, non-trigger accesses: write to 16'h4015, then read of 16'h4014 -> dma_busy stays 0 and cpu_rdy stays 1.
